// File: rtl/melody_pkg.sv
// melody_pkg: note entry types, pitch divider table and sequencer states for melody_seq.
package melody_pkg;

   typedef logic [3:0] pitch_t;

   typedef struct packed {
      pitch_t     pitch;
      logic [2:0] beats;
   } note_t;

   // 50 MHz / note frequency, C4..B5 diatonic; rest and reserved codes are 0
   localparam logic [31:0] PITCH_DIV [16] = '{
      32'd0,      32'd191110, 32'd170265, 32'd151685,
      32'd143172, 32'd127551, 32'd113636, 32'd101239,
      32'd95557,  32'd85131,  32'd75843,  32'd71586,
      32'd63776,  32'd56818,  32'd50619,  32'd0
   };

   typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, END} state_e;

   function automatic logic sounding(input pitch_t p);
      return p != 4'd0 && p != 4'd15;
   endfunction

endpackage

// File: rtl/melody_rom.sv
// melody_rom: combinational song table, index -> note entry; swap songs here only.
module melody_rom
   import melody_pkg::*;
#(
   parameter int SONG_LEN = 32
) (
   input  logic [$clog2(SONG_LEN)-1:0] idx,
   output note_t                       note
);

   localparam int IW = $clog2(SONG_LEN);

   always_comb begin
      case (idx)
         IW'(0):  note = '{pitch: 4'd1, beats: 3'd2};
         IW'(1):  note = '{pitch: 4'd0, beats: 3'd1};
         IW'(2):  note = '{pitch: 4'd3, beats: 3'd1};
         default: note = '{pitch: 4'd0, beats: 3'd0};
      endcase
   end

endmodule

// File: rtl/melody_seq.sv
// melody_seq: steps the note table and drives divnum/tone_en for the buzzer generator.
// Optional MELODY_PAUSE_EN adds a pause level input that freezes note and gap timing.
module melody_seq
   import melody_pkg::*;
#(
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_000_000,
   parameter int SONG_LEN    = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        loop,
`ifdef MELODY_PAUSE_EN
   input  logic                        pause,
`endif
   output logic [31:0]                 divnum,
   output logic                        tone_en,
   output logic                        busy,
   output logic [$clog2(SONG_LEN)-1:0] note_idx,
   output logic                        done
);

   localparam int IW = $clog2(SONG_LEN);

   state_e        state, adv_st;
   note_t         note;
   logic [31:0]   dur_cnt, gap_cnt;
   logic [34:0]   dur_full;
   logic [IW-1:0] adv_idx;
   logic          tone_q, frz, last;

   if (BEAT_CYCLES < 2) begin : g_beat_chk
      $error("melody_seq: BEAT_CYCLES must be at least 2");
   end
   if (35'(BEAT_CYCLES) * 35'd7 > 35'h0_FFFF_FFFF) begin : g_dur_chk
      $error("melody_seq: 7*BEAT_CYCLES does not fit the 32-bit duration counter");
   end

   melody_rom #(.SONG_LEN(SONG_LEN)) u_rom (.idx(note_idx), .note(note));

   assign dur_full = 35'(note.beats) * 35'(BEAT_CYCLES);
   // stepping past the last entry behaves like hitting the end marker
   assign last     = note_idx == IW'(SONG_LEN - 1);
   assign adv_idx  = last ? '0 : note_idx + IW'(1);
   assign adv_st   = last ? END : LOAD;

`ifdef MELODY_PAUSE_EN
   assign frz = pause && (state == PLAY || state == GAP);
`else
   assign frz = 1'b0;
`endif

   assign tone_en = tone_q && !frz;
   assign busy    = state != IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         divnum   <= '0;
         tone_q   <= 1'b0;
         note_idx <= '0;
         done     <= 1'b0;
         dur_cnt  <= '0;
         gap_cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state    <= IDLE;
            tone_q   <= 1'b0;
            note_idx <= '0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  state    <= LOAD;
                  note_idx <= '0;
               end
               LOAD: if (note.beats == 3'd0) state <= END;
               else begin
                  if (sounding(note.pitch)) divnum <= PITCH_DIV[note.pitch];
                  tone_q  <= sounding(note.pitch);
                  dur_cnt <= 32'(dur_full - 35'd1);
                  state   <= PLAY;
               end
               PLAY: if (!frz) begin
                  if (dur_cnt == '0) begin
                     tone_q <= 1'b0;
                     if (GAP_CYCLES > 0) begin
                        gap_cnt <= 32'(GAP_CYCLES - 1);
                        state   <= GAP;
                     end else begin
                        note_idx <= adv_idx;
                        state    <= adv_st;
                     end
                  end else dur_cnt <= dur_cnt - 32'd1;
               end
               GAP: if (!frz) begin
                  if (gap_cnt == '0) begin
                     note_idx <= adv_idx;
                     state    <= adv_st;
                  end else gap_cnt <= gap_cnt - 32'd1;
               end
               END: if (loop) begin
                  note_idx <= '0;
                  state    <= LOAD;
               end else begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq: randomized scoreboard bench; a phase-level song model predicts every observed cycle.
module tb_melody_seq;
   import melody_pkg::*;

   localparam int BC = 10;
   localparam int GC = 3;
   localparam int SL = 32;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
`ifdef MELODY_PAUSE_EN
   logic        pause = 1'b0;
`endif
   logic [31:0] divnum;
   logic        tone_en, busy, done;
   logic [4:0]  note_idx;

   melody_seq #(.BEAT_CYCLES(BC), .GAP_CYCLES(GC), .SONG_LEN(SL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
`ifdef MELODY_PAUSE_EN
      .pause(pause),
`endif
      .divnum(divnum), .tone_en(tone_en), .busy(busy), .note_idx(note_idx), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          tone, busy, done;
      logic [31:0] div;
      int          idx;
   } obs_t;

   // kind: 0 load, 1 play, 2 gap, 3 end, 4 done (idle with done pulse)
   typedef struct {
      int          kind, len;
      bit          tone;
      logic [31:0] div;
      int          idx;
   } ph_t;

   int song_p [4] = '{1, 0, 3, 0};
   int song_b [4] = '{2, 1, 1, 0};

   obs_t        exp_q[$];
   obs_t        tr[$];
   ph_t         ph[$];
   logic [31:0] mdiv = '0;
   int          n_cmp = 0, n_bad = 0;

   task automatic cmp(input string nm, input longint act, input longint ex);
      n_cmp++;
      if (act != ex) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, ex);
      end
   endtask

   always @(negedge clk) begin
      obs_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cmp("tone_en", tone_en, e.tone);
         cmp("busy", busy, e.busy);
         cmp("done", done, e.done);
         cmp("divnum", divnum, e.div);
         if (e.idx >= 0) cmp("note_idx", note_idx, e.idx);
      end
   end

   task automatic build(input bit lp, input int reps);
      logic [31:0] d = mdiv;
      bit snd;
      ph.delete();
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < 4; i++) begin
            ph.push_back('{kind: 0, len: 1, tone: 0, div: d, idx: i});
            if (song_b[i] == 0) begin
               ph.push_back('{kind: 3, len: 1, tone: 0, div: d, idx: i});
               if (!lp) ph.push_back('{kind: 4, len: 1, tone: 0, div: d, idx: -1});
               break;
            end
            snd = song_p[i] >= 1 && song_p[i] <= 14;
            if (snd) d = PITCH_DIV[song_p[i]];
            ph.push_back('{kind: 1, len: song_b[i] * BC, tone: snd, div: d, idx: i});
            ph.push_back('{kind: 2, len: GC, tone: 0, div: d, idx: i});
         end
         if (!lp) break;
      end
   endtask

   task automatic expand(input int pm, input int plen);
      int  pi = 0, used = 0;
      bit  pz;
      ph_t p;
      tr.delete();
      tr.push_back('{tone: 0, busy: 0, done: 0, div: mdiv, idx: -1});
      for (int j = 1; pi < ph.size(); j++) begin
         p  = ph[pi];
         pz = j >= pm && j < pm + plen && (p.kind == 1 || p.kind == 2);
         tr.push_back('{tone: p.tone && !pz, busy: p.kind != 4, done: p.kind == 4, div: p.div, idx: p.idx});
         if (!pz) begin
            used++;
            if (used == p.len) begin
               pi++;
               used = 0;
            end
         end
      end
   endtask

   task automatic run(input bit lp, input int reps, input int stopk, input int spur,
                      input int pm, input int plen, input int rk);
      obs_t z;
      build(lp, reps);
      expand(pm, plen);
      if (stopk >= 0) begin
         tr = tr[0:stopk];
         z  = '{tone: 0, busy: 0, done: 0, div: tr[stopk].div, idx: 0};
         repeat (4) tr.push_back(z);
      end else if (rk >= 0) begin
         tr = tr[0:rk-1];
         z  = '{tone: 0, busy: 0, done: 0, div: '0, idx: 0};
         repeat (6) tr.push_back(z);
      end else begin
         z = '{tone: 0, busy: 0, done: 0, div: tr[tr.size()-1].div, idx: -1};
         repeat (4) tr.push_back(z);
      end
      mdiv = tr[tr.size()-1].div;
      @(posedge clk); #1;
      foreach (tr[i]) exp_q.push_back(tr[i]);
      start = 1'b1;
      loop  = lp;
      for (int j = 1; j < tr.size(); j++) begin
         @(posedge clk); #1;
         start = j == spur;
         stop  = j == stopk;
`ifdef MELODY_PAUSE_EN
         pause = j >= pm && j < pm + plen;
`endif
         if (j == rk) begin
            #1 rst_n = 1'b0;
            #1;
            cmp("rst_tone_en", tone_en, 0);
            cmp("rst_busy", busy, 0);
            cmp("rst_done", done, 0);
            cmp("rst_divnum", divnum, 0);
            cmp("rst_note_idx", note_idx, 0);
         end
         if (j == rk + 2) rst_n = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
`ifdef MELODY_PAUSE_EN
      pause = 1'b0;
`endif
      for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(negedge clk);
      if (exp_q.size() > 0) begin
         cmp("scoreboard_drain", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   initial begin
      int mode, reps, maxb, stopk, rk, lim, spur, pm, plen;
      bit lp;
      repeat (3) @(posedge clk);
      #1;
      cmp("reset_tone_en", tone_en, 0);
      cmp("reset_busy", busy, 0);
      cmp("reset_done", done, 0);
      cmp("reset_divnum", divnum, 0);
      cmp("reset_note_idx", note_idx, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run(0, 1, -1, -1, 0, 0, -1);
      run(1, 3, 120, -1, 0, 0, -1);
      run(0, 1, 8, -1, 0, 0, -1);
      run(0, 1, -1, 10, 0, 0, -1);
      run(0, 1, -1, -1, 0, 0, 12);

      // start and stop together from IDLE must leave the sequencer idle
      @(posedge clk); #1;
      repeat (6) exp_q.push_back('{tone: 0, busy: 0, done: 0, div: mdiv, idx: -1});
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
      if (exp_q.size() > 0) begin
         cmp("idle_drain", exp_q.size(), 0);
         exp_q.delete();
      end

`ifdef MELODY_PAUSE_EN
      run(0, 1, -1, -1, 8, 15, -1);
      run(0, 1, -1, -1, 21, 5, -1);
`endif

      repeat (20) begin
         mode  = $urandom_range(0, 2);
         lp    = mode == 0 ? 1'b0 : 1'($urandom_range(0, 1));
         reps  = lp ? 2 : 1;
         maxb  = lp ? 107 : 53;
         stopk = mode == 1 ? int'($urandom_range(1, maxb)) : -1;
         rk    = mode == 2 ? int'($urandom_range(2, maxb)) : -1;
         lim   = mode == 1 ? stopk : mode == 2 ? rk - 1 : maxb;
         spur  = $urandom_range(0, 1) ? int'($urandom_range(1, lim)) : -1;
         pm    = 0;
         plen  = 0;
`ifdef MELODY_PAUSE_EN
         if ($urandom_range(0, 1)) begin
            pm   = $urandom_range(1, 50);
            plen = $urandom_range(1, 20);
         end
`endif
         run(lp, reps, stopk, spur, pm, plen, rk);
         repeat (2) @(posedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
